shift_unit_seq: RTL and testbench

Parametrised, multi-cycle shifter for the MIPS datapath. It replaces fixed shift-left-by-2/16 wiring with a general SLL/SRL/SRA/ROTR unit that takes a runtime shift amount. The unit shifts at most STEP bit positions per clock, which trades latency for a smaller barrel. It sits beside the ALU in the execute stage and uses a start/busy/done handshake so the pipeline control can stall while it works.

---
 rtl/shift_unit_seq.sv | 109 ++++++++++
 tb/tb_shift_unit_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/shift_unit_seq.sv
// Multi-cycle SLL/SRL/SRA/ROTR shifter, at most STEP bit positions per clock.
// done pulses 1+ceil(shamt/STEP) cycles after an accepted start; start is ignored while busy.
module shift_unit_seq #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [SW-1:0]    shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [SW:0] STEP_W = (SW+1)'(STEP);
    localparam logic [SW:0] WIDTH_W = (SW+1)'(WIDTH);

    state_t                 r_state;
    logic [WIDTH-1:0]       r_acc;
    logic [SW-1:0]          r_rem;
    logic [1:0]             r_op;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_gt;
    logic [SW-1:0]          w_k;
    logic [SW:0]            w_lsh;
    logic signed [WIDTH-1:0] w_sra;
    logic [WIDTH-1:0]       w_step;

    // STEP may equal WIDTH, so the compare is done one bit wider than rem.
    assign w_gt  = {1'b0, r_rem} > STEP_W;
    assign w_k   = w_gt ? STEP_W[SW-1:0] : r_rem;
    assign w_lsh = WIDTH_W - {1'b0, w_k};
    assign w_sra = $signed(r_acc) >>> w_k;

    always_comb begin
        w_step = r_acc;
        case (r_op)
            OP_SLL:  w_step = r_acc << w_k;
            OP_SRL:  w_step = r_acc >> w_k;
            OP_SRA:  w_step = w_sra;
            default: w_step = (r_acc >> w_k) | (r_acc << w_lsh);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_rem   <= '0;
            r_op    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_acc <= a;
                        r_rem <= shamt;
                        r_op  <= op;
                        if (shamt == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_acc <= w_step;
                    r_rem <= r_rem - w_k;
                    if (!w_gt) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign y    = r_acc;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed checks of shift_unit_seq with STEP=4 and STEP=1 instances sharing inputs.
module tb_shift_unit_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start4, start1;
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic        busy4, done4, busy1, done1;
    logic [31:0] y4, y1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    shift_unit_seq #(.WIDTH(32), .STEP(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .op(op), .a(a),
        .shamt(shamt), .busy(busy4), .done(done4), .y(y4)
    );

    shift_unit_seq #(.WIDTH(32), .STEP(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .op(op), .a(a),
        .shamt(shamt), .busy(busy1), .done(done1), .y(y1)
    );

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [4:0]  sh;
        logic [31:0] ey;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one operation and check latency, busy span, result and done pulse width.
    task automatic run_vec(input int sel, input vec_t v);
        int    dcyc;
        int    nbusy;
        logic  ovl;
        logic  b, d;
        logic [31:0] yv;
        dcyc  = -1;
        nbusy = 0;
        ovl   = 1'b0;
        yv    = '0;
        @(negedge clk);
        op = v.op; a = v.a; shamt = v.sh;
        if (sel == 1) start1 = 1'b1; else start4 = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (c == 1) begin
                start1 = 1'b0;
                start4 = 1'b0;
                a = 32'hA5A5A5A5;
                shamt = 5'd7;
            end
            b = (sel == 1) ? busy1 : busy4;
            d = (sel == 1) ? done1 : done4;
            if (b && d) ovl = 1'b1;
            if (b) nbusy++;
            if (d) begin
                dcyc = c;
                yv   = (sel == 1) ? y1 : y4;
                break;
            end
        end
        chk({v.name, " done_cycle"}, dcyc, v.lat);
        chk({v.name, " busy_cycles"}, nbusy, v.lat - 1);
        chk({v.name, " y"}, yv, v.ey);
        chk({v.name, " busy_done_overlap"}, {31'b0, ovl}, 32'd0);
        tick();
        chk({v.name, " done_one_cycle"}, {31'b0, (sel == 1) ? done1 : done4}, 32'd0);
        chk({v.name, " y_hold"}, (sel == 1) ? y1 : y4, v.ey);
    endtask

    vec_t vecs[9];

    initial begin
        int first_done, second_done, late_done;
        logic [31:0] first_y, second_y;
        logic saw_busy2;

        vecs[0] = '{"sll10",  2'b00, 32'h000000FF, 5'd10, 32'h0003FC00, 4};
        vecs[1] = '{"sra31",  2'b10, 32'h80000000, 5'd31, 32'hFFFFFFFF, 9};
        vecs[2] = '{"srl31",  2'b01, 32'h80000000, 5'd31, 32'h00000001, 9};
        vecs[3] = '{"rotr16", 2'b11, 32'h12345678, 5'd16, 32'h56781234, 5};
        vecs[4] = '{"srl0",   2'b01, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1};
        vecs[5] = '{"sra4",   2'b10, 32'h7FFF0000, 5'd4,  32'h07FFF000, 2};
        vecs[6] = '{"rotr3",  2'b11, 32'h0000000F, 5'd3,  32'hE0000001, 2};
        vecs[7] = '{"sra5",   2'b10, 32'hF0000000, 5'd5,  32'hFF800000, 3};
        vecs[8] = '{"sll31",  2'b00, 32'h00000001, 5'd31, 32'h80000000, 9};

        reset = 1'b1; start4 = 1'b0; start1 = 1'b0;
        op = 2'b00; a = 32'hFFFFFFFF; shamt = 5'd0;
        tick(); tick();
        chk("reset busy4", {31'b0, busy4}, 32'd0);
        chk("reset done4", {31'b0, done4}, 32'd0);
        chk("reset y4", y4, 32'd0);
        chk("reset y1", y1, 32'd0);
        reset = 1'b0;
        tick();

        foreach (vecs[i]) run_vec(4, vecs[i]);

        run_vec(1, '{"step1_rotr16", 2'b11, 32'h12345678, 5'd16, 32'h56781234, 17});
        run_vec(1, '{"step1_sra3", 2'b10, 32'h80000000, 5'd3, 32'hF0000000, 4});

        // Start during RUN is ignored; start held in the DONE cycle is accepted.
        first_done = -1; second_done = -1; first_y = '0; second_y = '0;
        saw_busy2 = 1'b0;
        @(negedge clk);
        op = 2'b00; a = 32'h000000FF; shamt = 5'd10; start4 = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) start4 = 1'b0;
            if (c == 2) begin
                start4 = 1'b1; op = 2'b00; a = 32'hFFFFFFFF; shamt = 5'd4;
            end
            if (c == 3) start4 = 1'b0;
            if (done4 && first_done < 0) begin
                first_done = c; first_y = y4;
                start4 = 1'b1; op = 2'b01; a = 32'hFFFFFFFF; shamt = 5'd4;
            end else if (done4 && second_done < 0) begin
                second_done = c; second_y = y4;
            end else if (c == first_done + 1 && first_done > 0) begin
                start4 = 1'b0;
                saw_busy2 = busy4;
            end
        end
        start4 = 1'b0;
        chk("ignore_start done_cycle", first_done, 4);
        chk("ignore_start y", first_y, 32'h0003FC00);
        chk("b2b busy", {31'b0, saw_busy2}, 32'd1);
        chk("b2b done_cycle", second_done, 6);
        chk("b2b y", second_y, 32'h0FFFFFFF);

        // Reset in cycle 2 of a long SLL aborts it with no trailing done.
        tick();
        @(negedge clk);
        op = 2'b00; a = 32'h00000001; shamt = 5'd20; start4 = 1'b1;
        late_done = 0;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (c == 1) start4 = 1'b0;
            if (c == 2) reset = 1'b1;
            if (c == 3) begin
                reset = 1'b0;
                chk("abort busy", {31'b0, busy4}, 32'd0);
                chk("abort done", {31'b0, done4}, 32'd0);
                chk("abort y", y4, 32'd0);
            end
            if (c > 3 && done4) late_done++;
        end
        chk("abort no_late_done", late_done, 0);
        run_vec(4, '{"after_abort", 2'b00, 32'h00000003, 5'd20, 32'h00300000, 6});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
